// File: rtl/inlier_stream_counter.sv
// Streaming RANSAC inlier counter: loads a line model, tests LANES packed points
// per word through a product/residual/square pipeline and accumulates the inlier total.
module inlier_stream_counter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned LANES   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  output logic [LANES-1:0]  inlier_mask,
  output logic              mask_valid,
  output logic [CNT_W-1:0]  inlier_count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned DW    = COORD_W + 1;
  localparam int unsigned BW    = 2 * COORD_W + 1;
  localparam int unsigned PW    = 2 * COORD_W + 2;
  localparam int unsigned RW    = 2 * COORD_W + 3;
  localparam int unsigned SW    = 2 * RW;
  localparam int unsigned THR_W = 32;

  typedef enum logic [2:0] {
    S_LOAD_DX, S_LOAD_DY, S_LOAD_BETA, S_LOAD_THR, S_LOAD_N, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [RW-1:0] resid_t;

  state_t                  state_q, state_d;
  logic signed [DW-1:0]    dx_q, dx_d, dy_q, dy_d;
  logic signed [BW-1:0]    beta_q, beta_d;
  logic [THR_W-1:0]        thr_q, thr_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [LANES-1:0]        v1_q, v1_d, v2_q, v2_d;
  prod_t                   p1_q [LANES];
  prod_t                   p1_d [LANES];
  prod_t                   p2_q [LANES];
  prod_t                   p2_d [LANES];
  resid_t                  r_q  [LANES];
  resid_t                  r_d  [LANES];
  logic [LANES-1:0]        mask_q, mask_d;
  logic                    mask_valid_q, mask_valid_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0]       data_out_q, data_out_d;

  logic [COORD_W-1:0]      lane_x, lane_y;
  logic signed [SW-1:0]    sq;
  logic [CNT_W-1:0]        pop, take;

  always_comb begin
    state_d      = state_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    beta_d       = beta_q;
    thr_d        = thr_q;
    rem_d        = rem_q;
    v1_d         = '0;
    v2_d         = v1_q;
    lane_x       = '0;
    lane_y       = '0;
    sq           = '0;
    pop          = '0;
    take         = '0;
    mask_d       = '0;

    // Pipeline datapath runs every cycle; only the lane-valid bits gate results.
    for (int k = 0; k < LANES; k++) begin
      lane_x  = data_in[2*COORD_W*k +: COORD_W];
      lane_y  = data_in[2*COORD_W*k + COORD_W +: COORD_W];
      p1_d[k] = PW'(dx_q) * PW'($signed({1'b0, lane_y}));
      p2_d[k] = PW'(dy_q) * PW'($signed({1'b0, lane_x}));
      r_d[k]  = RW'(p1_q[k]) - RW'(p2_q[k]) - RW'(beta_q);
      sq      = SW'(r_q[k]) * SW'(r_q[k]);
      mask_d[k] = v2_q[k] && ($unsigned(sq) <= SW'(thr_q));
      pop     = pop + CNT_W'(mask_d[k]);
    end
    mask_valid_d = |v2_q;
    count_d      = count_q + pop;

    case (state_q)
      S_LOAD_DX: if (enable) begin
        dx_d    = data_in[DW-1:0];
        state_d = S_LOAD_DY;
      end
      S_LOAD_DY: if (enable) begin
        dy_d    = data_in[DW-1:0];
        state_d = S_LOAD_BETA;
      end
      S_LOAD_BETA: if (enable) begin
        beta_d  = data_in[BW-1:0];
        state_d = S_LOAD_THR;
      end
      S_LOAD_THR: if (enable) begin
        thr_d   = THR_W'(data_in);
        state_d = S_LOAD_N;
      end
      S_LOAD_N: if (enable) begin
        rem_d   = data_in[CNT_W-1:0];
        count_d = '0;
        state_d = (data_in[CNT_W-1:0] == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: if (enable) begin
        for (int k = 0; k < LANES; k++) begin
          v1_d[k] = CNT_W'(k) < rem_q;
        end
        take  = (rem_q < CNT_W'(LANES)) ? rem_q : CNT_W'(LANES);
        rem_d = rem_q - take;
        if (rem_d == '0) state_d = S_DRAIN;
      end
      S_DRAIN: if (v1_q == '0 && v2_q == '0) begin
        state_d = S_DONE;
      end
      S_DONE: if (enable) begin
        dx_d    = data_in[DW-1:0];
        state_d = S_LOAD_DY;
      end
      default: state_d = S_LOAD_DX;
    endcase

    // Abort flushes in-flight words so they never produce a mask pulse.
    if (abort) begin
      state_d      = S_LOAD_DX;
      rem_d        = '0;
      v1_d         = '0;
      v2_d         = '0;
      mask_d       = '0;
      mask_valid_d = 1'b0;
      count_d      = '0;
    end

    busy_d     = (state_d == S_STREAM) || (state_d == S_DRAIN);
    done_d     = (state_d == S_DONE);
    data_out_d = done_d ? DATA_W'(count_d) : DATA_W'(mask_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_LOAD_DX;
      dx_q         <= '0;
      dy_q         <= '0;
      beta_q       <= '0;
      thr_q        <= '0;
      rem_q        <= '0;
      count_q      <= '0;
      v1_q         <= '0;
      v2_q         <= '0;
      p1_q         <= '{default: '0};
      p2_q         <= '{default: '0};
      r_q          <= '{default: '0};
      mask_q       <= '0;
      mask_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      beta_q       <= beta_d;
      thr_q        <= thr_d;
      rem_q        <= rem_d;
      count_q      <= count_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      r_q          <= r_d;
      mask_q       <= mask_d;
      mask_valid_q <= mask_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      data_out_q   <= data_out_d;
    end
  end

  assign inlier_mask  = mask_q;
  assign mask_valid   = mask_valid_q;
  assign inlier_count = count_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign data_out     = data_out_q;

endmodule
